// File: rtl/calc_energy_seq_if.sv
// ---------------------------------------------------------------------------
// calc_energy_seq_if
// Handshake bundle between the candidate-sequence generator, the energy
// calculator and the best-energy tracker.
//   a          sequence, a[i]=1 means s_i=+1, a[i]=0 means s_i=-1
//   in_valid   producer presents a sequence on a
//   in_ready   calculator can accept a sequence
//   energy     LABS energy E = sum C_k^2, unsigned, saturating
//   peak       peak sidelobe max |C_k|
//   overflow   energy was clamped at 2^E_WIDTH-1
//   out_valid  energy/peak/overflow hold a complete result
//   out_ready  consumer accepts the result
// Modports: master = producer/consumer side, slave = calculator side.
// ---------------------------------------------------------------------------
interface calc_energy_seq_if #(
    parameter int SEQ_WIDTH = 40,
    parameter int E_WIDTH   = 16
);
    logic [SEQ_WIDTH-1:0] a;
    logic                 in_valid;
    logic                 in_ready;
    logic [E_WIDTH-1:0]   energy;
    logic [7:0]           peak;
    logic                 overflow;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output a, in_valid, out_ready,
        input  in_ready, energy, peak, overflow, out_valid
    );

    modport slave (
        input  a, in_valid, out_ready,
        output in_ready, energy, peak, overflow, out_valid
    );
endinterface

// File: rtl/calc_energy_seq.sv
// ---------------------------------------------------------------------------
// calc_energy_seq
// Multi-cycle LABS energy calculator. Accepts one +/-1 sequence, evaluates
// the aperiodic autocorrelations C_k for k = 1..SEQ_WIDTH-1, LANES shifts
// per cycle, and accumulates E = sum C_k^2 (saturating) and max |C_k|.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   calc_energy_seq_if.slave (a/in_valid/in_ready in,
//         energy/peak/overflow/out_valid/out_ready out)
// Latency: ceil((SEQ_WIDTH-1)/LANES) cycles from accept to out_valid.
// ---------------------------------------------------------------------------
module calc_energy_seq #(
    parameter int SEQ_WIDTH = 40,
    parameter int LANES     = 4,
    parameter int E_WIDTH   = 16
) (
    input logic              clk,
    input logic              rst,
    calc_energy_seq_if.slave bus
);

    // Shift index must hold the largest k + LANES reached before DONE.
    localparam int KW   = $clog2(SEQ_WIDTH + LANES + 1);
    // Holds N-k and 2*popcount (both < 512 for N <= 255).
    localparam int CW   = 10;
    // |C| <= 254, so C^2 fits 16 bits; the sum adds room for LANES terms
    // plus the running energy so nothing wraps before the clamp.
    localparam int SUMW = E_WIDTH + 16 + $clog2(LANES + 1) + 1;
    localparam logic [SUMW-1:0] E_MAX = {{(SUMW-E_WIDTH){1'b0}}, {E_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q;
    logic [SEQ_WIDTH-1:0] seq_q;
    logic [KW-1:0]        k_q;
    logic [E_WIDTH-1:0]   energy_q;
    logic [7:0]           peak_q;
    logic                 overflow_q;

    logic [SUMW-1:0]      sq_sum;
    logic [SUMW-1:0]      sum_full;
    logic                 sat_ovf;
    logic [E_WIDTH-1:0]   energy_next;
    logic [7:0]           cyc_peak;
    logic                 last_run;
    logic                 in_ready;
    logic                 accept;

    // |C_k| for one shift: (N-k) - 2*popcount(s[i] ^ s[i+k]) over the
    // overlapping N-k positions. Caller guarantees k <= N-1.
    function automatic logic [7:0] lane_mag(input logic [SEQ_WIDTH-1:0] s,
                                            input logic [KW-1:0]        kj);
        logic [SEQ_WIDTH-1:0] diff;
        logic [CW-1:0]        len;
        logic [CW-1:0]        pop2;
        diff = s ^ (s >> kj);
        len  = CW'(SEQ_WIDTH) - CW'(kj);
        pop2 = '0;
        for (int i = 0; i < SEQ_WIDTH; i++) begin
            if (CW'(i) < len) begin
                pop2 = pop2 + {{(CW-1){1'b0}}, diff[i]};
            end
        end
        pop2 = pop2 << 1;
        if (pop2 > len) begin
            lane_mag = 8'(pop2 - len);
        end else begin
            lane_mag = 8'(len - pop2);
        end
    endfunction

    // Per-cycle lane evaluation, saturating accumulate and peak update.
    always_comb begin
        logic [KW-1:0] kj;
        logic [7:0]    mag;
        logic [15:0]   mag16;
        sq_sum   = '0;
        cyc_peak = peak_q;
        for (int j = 0; j < LANES; j++) begin
            kj  = k_q + KW'(j);
            mag = '0;
            // Lanes past k = N-1 in the final cycle contribute nothing.
            if (kj <= KW'(SEQ_WIDTH - 1)) begin
                mag = lane_mag(seq_q, kj);
            end
            mag16  = {8'b0, mag};
            sq_sum = sq_sum + SUMW'(mag16 * mag16);
            if (mag > cyc_peak) begin
                cyc_peak = mag;
            end
        end
        sum_full    = SUMW'(energy_q) + sq_sum;
        sat_ovf     = sum_full > E_MAX;
        energy_next = sat_ovf ? {E_WIDTH{1'b1}} : sum_full[E_WIDTH-1:0];
    end

    assign last_run = (k_q + KW'(LANES)) > KW'(SEQ_WIDTH - 1);

    // Ready in DONE only when the current result is being taken, so a new
    // sequence can be accepted on the same edge the result is released.
    assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    assign accept   = bus.in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain updates in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: seq_q is reset too; it is a single register, not a memory,
            // and a known value keeps the datapath free of X after reset.
            state_q    <= IDLE;
            seq_q      <= '0;
            k_q        <= '0;
            energy_q   <= '0;
            peak_q     <= '0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            seq_q      <= bus.a;
            k_q        <= KW'(1);
            energy_q   <= '0;
            peak_q     <= '0;
            overflow_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            case (state_q)
                RUN: begin
                    energy_q   <= energy_next;
                    overflow_q <= overflow_q | sat_ovf;
                    peak_q     <= cyc_peak;
                    k_q        <= k_q + KW'(LANES);
                    if (last_run) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.energy    = energy_q;
    assign bus.peak      = peak_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_calc_energy_seq.sv
// ---------------------------------------------------------------------------
// tb_calc_energy_seq
// Self-checking bench for calc_energy_seq. Three instances cover
// N=40/LANES=4/E_WIDTH=16, N=13/LANES=4/E_WIDTH=16 and N=40/LANES=4/E_WIDTH=14.
// Expected results come from a direct +/-1 autocorrelation model.
// ---------------------------------------------------------------------------
module tb_calc_energy_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int          sel;
    logic [39:0] drv_a;
    logic        drv_in_valid;
    logic        drv_out_ready;

    calc_energy_seq_if #(.SEQ_WIDTH(40), .E_WIDTH(16)) bus_a ();
    calc_energy_seq_if #(.SEQ_WIDTH(13), .E_WIDTH(16)) bus_b ();
    calc_energy_seq_if #(.SEQ_WIDTH(40), .E_WIDTH(14)) bus_c ();

    assign bus_a.a         = drv_a;
    assign bus_a.in_valid  = drv_in_valid && (sel == 0);
    assign bus_a.out_ready = drv_out_ready;
    assign bus_b.a         = drv_a[12:0];
    assign bus_b.in_valid  = drv_in_valid && (sel == 1);
    assign bus_b.out_ready = drv_out_ready;
    assign bus_c.a         = drv_a;
    assign bus_c.in_valid  = drv_in_valid && (sel == 2);
    assign bus_c.out_ready = drv_out_ready;

    calc_energy_seq #(.SEQ_WIDTH(40), .LANES(4), .E_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    calc_energy_seq #(.SEQ_WIDTH(13), .LANES(4), .E_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));
    calc_energy_seq #(.SEQ_WIDTH(40), .LANES(4), .E_WIDTH(14)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c));

    logic [31:0] obs_energy;
    logic [7:0]  obs_peak;
    logic        obs_ovf;
    logic        obs_valid;
    logic        obs_ready;

    always_comb begin
        case (sel)
            1: begin
                obs_energy = 32'(bus_b.energy);
                obs_peak   = bus_b.peak;
                obs_ovf    = bus_b.overflow;
                obs_valid  = bus_b.out_valid;
                obs_ready  = bus_b.in_ready;
            end
            2: begin
                obs_energy = 32'(bus_c.energy);
                obs_peak   = bus_c.peak;
                obs_ovf    = bus_c.overflow;
                obs_valid  = bus_c.out_valid;
                obs_ready  = bus_c.in_ready;
            end
            default: begin
                obs_energy = 32'(bus_a.energy);
                obs_peak   = bus_a.peak;
                obs_ovf    = bus_a.overflow;
                obs_valid  = bus_a.out_valid;
                obs_ready  = bus_a.in_ready;
            end
        endcase
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // C_k = sum over overlapping positions of s_i * s_{i+k}, with s = +/-1.
    function automatic void model(input logic [39:0] val, input int n, input int ew,
                                  output longint e, output int pk, output bit ovf);
        longint sum;
        longint limit;
        int     c;
        int     m;
        sum = 0;
        pk  = 0;
        for (int k = 1; k < n; k++) begin
            c = 0;
            for (int i = 0; i + k < n; i++) begin
                c += (val[i] == val[i+k]) ? 1 : -1;
            end
            sum += longint'(c * c);
            m = (c < 0) ? -c : c;
            if (m > pk) pk = m;
        end
        limit = (longint'(1) << ew) - 1;
        ovf   = (sum > limit);
        e     = ovf ? limit : sum;
    endfunction

    // Called at a negedge: presents the sequence, accepts it on the next
    // posedge (edge 0) and returns at the following negedge.
    task automatic start(input int s, input logic [39:0] val);
        sel          = s;
        drv_a        = val;
        drv_in_valid = 1'b1;
        #1;
        check("in_ready_at_accept", obs_ready, 1);
        @(posedge clk);
        @(negedge clk);
        drv_in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_done(input string tag, input int exp_r);
        int cycles;
        cycles = 0;
        while (!obs_valid && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, cycles, exp_r);
        check({tag, "_out_valid"}, obs_valid, 1);
    endtask

    task automatic run_and_check(input string tag, input int s, input logic [39:0] val);
        int     n;
        int     ew;
        int     r;
        longint e;
        int     pk;
        bit     ovf;
        n  = (s == 1) ? 13 : 40;
        ew = (s == 2) ? 14 : 16;
        r  = (n - 1 + 3) / 4;
        start(s, val);
        wait_done(tag, r);
        model(val, n, ew, e, pk, ovf);
        check({tag, "_energy"}, obs_energy, e);
        check({tag, "_peak"}, obs_peak, pk);
        check({tag, "_overflow"}, obs_ovf, ovf);
    endtask

    initial begin
        logic [39:0] ones;
        logic [39:0] barker;
        logic [39:0] rv;
        logic [31:0] hold_e;
        logic [7:0]  hold_p;
        logic        hold_o;
        bit          saw_valid;
        int          s;

        ones          = {40{1'b1}};
        barker        = 40'(13'b1111100110101);
        sel           = 0;
        drv_a         = '0;
        drv_in_valid  = 1'b0;
        drv_out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", obs_ready, 0);
        check("rst_energy", obs_energy, 0);
        check("rst_peak", obs_peak, 0);
        check("rst_overflow", obs_ovf, 0);
        check("rst_out_valid", obs_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", obs_ready, 1);

        // Directed: all ones, alternating, Barker-13, saturating width
        run_and_check("ones_a", 0, ones);
        check("ones_a_energy_const", obs_energy, 20540);
        check("ones_a_peak_const", obs_peak, 39);
        run_and_check("alt_a", 0, 40'hAAAAAAAAAA);
        check("alt_a_energy_const", obs_energy, 20540);
        run_and_check("barker_b", 1, barker);
        check("barker_b_energy_const", obs_energy, 6);
        check("barker_b_peak_const", obs_peak, 1);
        run_and_check("ones_c", 2, ones);
        check("ones_c_energy_const", obs_energy, 16383);
        check("ones_c_overflow_const", obs_ovf, 1);

        // Back-pressure in DONE, then back-to-back accept
        @(negedge clk);
        drv_out_ready = 1'b0;
        start(0, ones);
        wait_done("bp", 10);
        hold_e = obs_energy;
        hold_p = obs_peak;
        hold_o = obs_ovf;
        check("bp_in_ready_low", obs_ready, 0);
        repeat (5) begin
            @(negedge clk);
            check("bp_energy_stable", obs_energy, hold_e);
            check("bp_peak_stable", obs_peak, hold_p);
            check("bp_overflow_stable", obs_ovf, hold_o);
            check("bp_out_valid_held", obs_valid, 1);
            check("bp_in_ready_held_low", obs_ready, 0);
        end
        drv_out_ready = 1'b1;
        start(0, 40'h0);
        wait_done("b2b", 10);
        check("b2b_energy", obs_energy, 20540);

        // Reset in the middle of a run
        @(negedge clk);
        start(0, {$urandom, $urandom});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready_low", obs_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_energy", obs_energy, 0);
        check("midrst_peak", obs_peak, 0);
        check("midrst_overflow", obs_ovf, 0);
        check("midrst_out_valid", obs_valid, 0);
        check("midrst_in_ready", obs_ready, 1);
        saw_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (obs_valid) saw_valid = 1'b1;
        end
        check("midrst_no_out_valid", saw_valid, 0);
        run_and_check("barker_after_rst", 1, barker);
        check("barker_after_rst_energy_const", obs_energy, 6);

        // Randomized sequences across all three configurations
        for (int it = 0; it < 24; it++) begin
            s  = int'($urandom_range(0, 2));
            rv = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                rv = ~(40'(1) << $urandom_range(0, 39));
            end
            run_and_check("rand", s, rv);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/calc_energy_seq.md
# calc_energy_seq

Multi-cycle, parametrised successor to the pipelined single-shift C_k calculator. It accepts one binary sequence and computes every aperiodic autocorrelation C_k for k = 1..SEQ_WIDTH-1, LANES shifts per cycle. It accumulates the LABS energy E = sum(C_k^2) and tracks the peak sidelobe max|C_k|. It sits between the candidate-sequence generator and the best-energy tracker, with valid/ready handshakes on both sides.

## Interface
- SEQ_WIDTH, 40, sequence length N; legal range 2..255.
- LANES, 4, number of shifts k evaluated per cycle; legal range 1..SEQ_WIDTH-1.
- E_WIDTH, 16, width of the energy result; the result saturates on overflow.
- clk  input  1  single clock; all state is updated on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- a  input  SEQ_WIDTH  sequence; a[i]=1 means s_i=+1, a[i]=0 means s_i=-1.
- in_valid  input  1  a is valid.
- in_ready  output  1  block can accept a sequence.
- energy  output  E_WIDTH  E, unsigned, saturating.
- peak  output  8  max over k of |C_k|, unsigned.
- overflow  output  1  E exceeded 2^E_WIDTH-1 and was clamped.
- out_valid  output  1  energy/peak/overflow hold a complete result.
- out_ready  input  1  downstream accepts the result.

## Operation
- States:
  - IDLE: waiting for a sequence.
  - RUN: accumulating.
  - DONE: result held.
- Combinational handshakes:
  - in_ready = ~rst & (IDLE | (DONE & out_ready)).
  - out_valid = (state == DONE).
- Accept: in_valid & in_ready at an edge. On that edge:
  - a is captured into the seq register.
  - k is set to 1; energy, peak and overflow are cleared to 0.
  - State goes to RUN.
- RUN cycle, for lane j = 0..LANES-1, with kj = k+j:
  - If kj <= N-1: C = (N-kj) - 2*popcount(seq[N-kj-1:0] ^ seq[N-1:kj]). C is signed, with |C| <= N-kj.
  - If kj > N-1: the lane contributes C = 0.
  - energy <= sat(energy + sum of C^2). Sum intermediates are at least E_WIDTH+1 bits wide, so no wrap occurs before the clamp.
  - overflow is set sticky if the unclamped sum exceeds 2^E_WIDTH-1.
  - peak <= max(peak, all |C| this cycle).
  - k <= k + LANES.
  - If k + LANES > N-1 this is the last RUN cycle, and the next state is DONE.
- DONE:
  - energy, peak and overflow are held stable while out_valid=1 and out_ready=0.
  - out_ready=1 with in_valid=0: next state is IDLE. Outputs retain their values; out_valid falls.
  - out_ready=1 with in_valid=1 in the same cycle: result released and new sequence accepted on the same edge; next state is RUN. This allows back-to-back operation with no bubble.
- in_valid in RUN is ignored because in_ready=0; a must not be sampled.
- energy and peak follow the accumulators during RUN. They are meaningful only while out_valid=1.

## Timing
- Reset (rst high at an edge):
  - state becomes IDLE.
  - energy=0, peak=0, overflow=0, out_valid=0.
  - in_ready is 0 while rst is high and 1 the cycle after.
- Reset mid-RUN or in DONE: the in-flight result is discarded, with no out_valid pulse.
- R = ceil((N-1)/LANES) RUN cycles.
- If accept happens at edge 0, RUN edges are 1..R and out_valid=1 from edge R onward. Latency is R cycles; for N=40, LANES=4, R=10.
- Throughput: one sequence per R cycles when out_ready is held at 1.
- LANES=N-1 gives R=1.
- A last cycle with partially empty lanes (for example N=40, LANES=4, k=37..40) adds exactly 0 for k=40.

## Test plan
- N=40, LANES=4, E_WIDTH=16, a = all ones, out_ready=1:
  - out_valid exactly 10 cycles after accept.
  - energy=20540, peak=39, overflow=0.
- N=40, a = 40'hAAAAAAAAAA (alternating):
  - energy=20540 (C_k = ±(N-k)), peak=39.
- N=13, LANES=4, a = 13'b1111100110101 (Barker-13):
  - energy=6, peak=1, R=3.
- N=40, E_WIDTH=14, a = all ones:
  - energy=16383, overflow=1, peak=39.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE: outputs are stable and in_ready=0.
  - Then raise out_ready with in_valid=1 (a = all zeros): new accept on the same edge.
  - Second result out_valid exactly R cycles later, energy=20540.
- Reset mid-operation:
  - Assert rst at RUN cycle 4 for 1 cycle: out_valid never rises and all outputs read 0.
  - in_ready=1 the cycle after.
  - A fresh Barker-13 (N=13) run then gives energy=6.
